// File: rtl/serial_pkg.sv
// Shared types and helpers for the configurable serial transmitter.
// Optional SERIAL_TX_BREAK_EN adds the BREAK state to tx_state_t.
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

`ifdef SERIAL_TX_BREAK_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`endif

    // Frame length in bit periods: start + data + optional parity + stop.
    function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/serial_tx_cfg_baud_tick.sv
// Fractional baud-tick generator: accumulates BIT_FREQ per cycle modulo CLK_FREQ
// and pulses tick for one cycle on each wrap. restart holds the phase at zero.
module baud_tick #(
    parameter int CLK_FREQ = 16,
    parameter int BIT_FREQ = 1
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int ACC_W = $clog2(CLK_FREQ) + 1;
    localparam logic [ACC_W-1:0] INC = ACC_W'(BIT_FREQ);
    localparam logic [ACC_W-1:0] MOD = ACC_W'(CLK_FREQ);

    generate
        if (BIT_FREQ < 1 || BIT_FREQ > CLK_FREQ / 2) begin : g_bad_rate
            $error("baud_tick: BIT_FREQ must lie in 1..CLK_FREQ/2");
        end
    endgenerate

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             wrap;

    // acc < CLK_FREQ and BIT_FREQ <= CLK_FREQ/2, so the sum fits in ACC_W bits.
    always_comb begin
        acc_sum = acc + INC;
        wrap    = (acc_sum >= MOD);
        tick    = wrap && !restart;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (restart) begin
            acc <= '0;
        end else if (wrap) begin
            acc <= acc_sum - MOD;
        end else begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/serial_tx_cfg.sv
// Configurable async-serial transmitter with valid/ready input and fractional baud.
// Optional break generation is enabled by defining SERIAL_TX_BREAK_EN.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | line at mark, ready for a word
// ST_START  | start bit (tx=0)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (only when PARITY != PAR_NONE)
// ST_STOP   | STOP_BITS stop bits (tx=1)
// ST_BREAK  | line held at space while brk is high (macro only)
module serial_tx_cfg
    import serial_pkg::*;
#(
    parameter int CLK_FREQ  = 16,
    parameter int BIT_FREQ  = 1,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
`ifdef SERIAL_TX_BREAK_EN
    input  logic                 brk,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 busy,
    output logic                 tx
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("serial_tx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
            $error("serial_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("serial_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       PAR_INV   = 1'(PARITY == PAR_ODD);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [3:0]           cnt;
    logic                 restart;
    logic                 tick;

`ifdef SERIAL_TX_BREAK_EN
    assign restart = (state == ST_IDLE) || (state == ST_BREAK);
`else
    assign restart = (state == ST_IDLE);
`endif

    baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BIT_FREQ (BIT_FREQ)
    ) u_baud_tick (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            par_bit  <= 1'b0;
            cnt      <= '0;
            tx       <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef SERIAL_TX_BREAK_EN
                    if (brk) begin
                        state    <= ST_BREAK;
                        tx       <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else
`endif
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
                        par_bit  <= (^in_data) ^ PAR_INV;
                        state    <= ST_START;
                        tx       <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                        cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (cnt == LAST_DATA) begin
                            cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            // tx shows the next bit as it moves into shreg[0]
                            shreg <= shreg >> 1;
                            tx    <= shreg[1];
                            cnt   <= cnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (cnt == LAST_STOP) begin
                            state    <= ST_IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
`ifdef SERIAL_TX_BREAK_EN
                ST_BREAK: begin
                    if (!brk) begin
                        state    <= ST_IDLE;
                        tx       <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    tx       <= 1'b1;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_cfg.sv
// Bench for serial_tx_cfg: four frame configurations checked every cycle against
// a bit-boundary model, plus literal checks of the worked examples.
module tb_serial_tx_cfg;
    import serial_pkg::*;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] vld     = '0;
    logic [3:0] brk_s   = '0;
    logic [3:0] rdy;
    logic [3:0] busy;
    logic [3:0] txo;
    logic [7:0] d0 = '0;
    logic [6:0] d1 = '0;
    logic [6:0] d2 = '0;
    logic [7:0] d3 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // lanes: 0 = 8N1 16/1, 1 = 7E2 16/1, 2 = 7O2 16/1, 3 = 8N1 16/3
    localparam int LC [4] = '{16, 16, 16, 16};
    localparam int LB [4] = '{1, 1, 1, 3};
    localparam int LD [4] = '{8, 7, 7, 8};
    localparam int LP [4] = '{0, 2, 1, 0};
    localparam int LS [4] = '{1, 2, 2, 1};

    always #5 sys_clk = ~sys_clk;

    serial_tx_cfg #(.CLK_FREQ(16), .BIT_FREQ(1), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .sys_clk(sys_clk), .rst_n(rst_n),
`ifdef SERIAL_TX_BREAK_EN
        .brk(brk_s[0]),
`endif
        .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(d0), .busy(busy[0]), .tx(txo[0]));

    serial_tx_cfg #(.CLK_FREQ(16), .BIT_FREQ(1), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_7e2 (
        .sys_clk(sys_clk), .rst_n(rst_n),
`ifdef SERIAL_TX_BREAK_EN
        .brk(brk_s[1]),
`endif
        .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(d1), .busy(busy[1]), .tx(txo[1]));

    serial_tx_cfg #(.CLK_FREQ(16), .BIT_FREQ(1), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2)) u_7o2 (
        .sys_clk(sys_clk), .rst_n(rst_n),
`ifdef SERIAL_TX_BREAK_EN
        .brk(brk_s[2]),
`endif
        .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(d2), .busy(busy[2]), .tx(txo[2]));

    serial_tx_cfg #(.CLK_FREQ(16), .BIT_FREQ(3), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_frac (
        .sys_clk(sys_clk), .rst_n(rst_n),
`ifdef SERIAL_TX_BREAK_EN
        .brk(brk_s[3]),
`endif
        .in_valid(vld[3]), .in_ready(rdy[3]), .in_data(d3), .busy(busy[3]), .tx(txo[3]));

    // Model: frame as a list of bits; bit k ends at cycle ceil(k*CLK/BIT) after acceptance.
    int   m_busy [4];
    int   m_brk  [4];
    int   m_t    [4];
    int   m_T    [4];
    int   m_n    [4];
    logic m_bits [4][16];

    task automatic check(input string name, input int lane, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s lane %0d: got %0d expected %0d at %0t", name, lane, act, exp, $time);
        end
    endtask

    function automatic int bnd(input int l, input int k);
        return (k * LC[l] + LB[l] - 1) / LB[l];
    endfunction

    function automatic int bit_idx(input int l);
        int k = 0;
        while (k < m_n[l] && bnd(l, k + 1) <= m_t[l]) k++;
        return k;
    endfunction

    function automatic logic [8:0] lane_data(input int l);
        case (l)
            0:       return {1'b0, d0};
            1:       return {2'b0, d1};
            2:       return {2'b0, d2};
            default: return {1'b0, d3};
        endcase
    endfunction

    task automatic load(input int l, input logic [8:0] w);
        int n = 1;
        int ones = 0;
        m_bits[l][0] = 1'b0;
        for (int i = 0; i < LD[l]; i++) begin
            m_bits[l][n] = w[i];
            ones += int'(w[i]);
            n++;
        end
        if (LP[l] == 1) begin
            m_bits[l][n] = (ones % 2 == 0);
            n++;
        end else if (LP[l] == 2) begin
            m_bits[l][n] = (ones % 2 == 1);
            n++;
        end
        for (int i = 0; i < LS[l]; i++) begin
            m_bits[l][n] = 1'b1;
            n++;
        end
        m_n[l]    = n;
        m_T[l]    = bnd(l, n);
        m_t[l]    = 0;
        m_busy[l] = 1;
    endtask

    always @(posedge sys_clk or negedge rst_n) begin
        for (int l = 0; l < 4; l++) begin
            if (!rst_n) begin
                m_busy[l] = 0;
                m_brk[l]  = 0;
            end else if (m_busy[l] != 0) begin
                m_t[l]++;
                if (m_t[l] >= m_T[l]) m_busy[l] = 0;
            end else if (m_brk[l] != 0) begin
                if (!brk_s[l]) m_brk[l] = 0;
            end else if (brk_s[l]) begin
                m_brk[l] = 1;
            end else if (vld[l]) begin
                load(l, lane_data(l));
            end
        end
    end

    int e_tx;
    int e_rdy;
    always @(negedge sys_clk) begin
        for (int l = 0; l < 4; l++) begin
            if (m_brk[l] != 0) begin
                e_tx  = 0;
                e_rdy = 0;
            end else if (m_busy[l] != 0) begin
                e_tx  = int'(m_bits[l][bit_idx(l)]);
                e_rdy = 0;
            end else begin
                e_tx  = 1;
                e_rdy = 1;
            end
            check("tx", l, int'(txo[l]), e_tx);
            check("in_ready", l, int'(rdy[l]), e_rdy);
            check("busy", l, int'(busy[l]), 1 - e_rdy);
        end
    end

    task automatic send(input int l, input logic [8:0] w);
        @(negedge sys_clk);
        case (l)
            0:       d0 = w[7:0];
            1:       d1 = w[6:0];
            2:       d2 = w[6:0];
            default: d3 = w[7:0];
        endcase
        vld[l] = 1'b1;
        @(negedge sys_clk);
        vld[l] = 1'b0;
    endtask

    task automatic wait_ready(input int l, input int limit);
        int c = 0;
        while (!rdy[l] && c < limit) begin
            @(negedge sys_clk);
            c++;
        end
        check("ready_timeout", l, int'(rdy[l]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        logic [9:0] seq;

        check("frame_len_8n1", 0, frame_len(8, PAR_NONE, 1), 10);
        check("frame_len_7e2", 1, frame_len(7, PAR_EVEN, 2), 11);
        repeat (3) @(negedge sys_clk);
        check("reset_tx", 0, int'(txo[0]), 1);
        check("reset_ready", 0, int'(rdy[0]), 1);
        check("reset_busy", 0, int'(busy[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // 8N1 'K': mid-bit samples and in_ready low time
        send(0, 9'h04B);
        check("start_latency", 0, int'(txo[0]), 0);
        repeat (8) @(negedge sys_clk);
        for (int k = 0; k < 10; k++) begin
            seq[k] = txo[0];
            if (k < 9) repeat (16) @(negedge sys_clk);
        end
        check("k_bits", 0, int'(seq), int'(10'b1010010110));
        cnt = 152;
        while (!rdy[0] && cnt < 400) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("k_ready_low", 0, cnt, 160);

        // 7E2 and 7O2 on 0x41
        @(negedge sys_clk);
        d1 = 7'h41;
        d2 = 7'h41;
        vld[1] = 1'b1;
        vld[2] = 1'b1;
        @(negedge sys_clk);
        vld[1] = 1'b0;
        vld[2] = 1'b0;
        repeat (24) @(negedge sys_clk);
        check("7e2_d0", 1, int'(txo[1]), 1);
        repeat (112) @(negedge sys_clk);
        check("7e2_parity", 1, int'(txo[1]), 0);
        check("7o2_parity", 2, int'(txo[2]), 1);
        cnt = 136;
        while (!rdy[1] && cnt < 400) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("7e2_len", 1, cnt, 176);
        wait_ready(2, 50);

        // fractional 16/3
        send(3, 9'h000);
        cnt = 0;
        while (!txo[3] && cnt < 200) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("frac_low", 3, cnt, 48);
        while (!rdy[3] && cnt < 200) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("frac_frame", 3, cnt, 54);
        send(3, 9'h0FF);
        cnt = 0;
        while (!txo[3] && cnt < 200) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("frac_first_bit", 3, cnt, 6);
        wait_ready(3, 200);

        // back-to-back 0x55 then 0xAA; the mid-frame data change must not leak
        @(negedge sys_clk);
        d0 = 8'h55;
        vld[0] = 1'b1;
        @(negedge sys_clk);
        d0 = 8'hAA;
        cnt = 0;
        while (!rdy[0] && cnt < 400) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("b2b_first_len", 0, cnt, 160);
        check("b2b_gap_tx", 0, int'(txo[0]), 1);
        @(negedge sys_clk);
        check("b2b_gap_one", 0, int'(rdy[0]), 0);
        check("b2b_second_start", 0, int'(txo[0]), 0);
        vld[0] = 1'b0;
        wait_ready(0, 200);

        // reset during data bit 3 (0x33 has a 0 there)
        send(0, 9'h033);
        repeat (70) @(negedge sys_clk);
        check("pre_reset_tx", 0, int'(txo[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx", 0, int'(txo[0]), 1);
        check("async_reset_ready", 0, int'(rdy[0]), 1);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        send(0, 9'h00F);
        repeat (8) @(negedge sys_clk);
        check("post_reset_start", 0, int'(txo[0]), 0);
        repeat (16) @(negedge sys_clk);
        check("post_reset_d0", 0, int'(txo[0]), 1);
        wait_ready(0, 200);

`ifdef SERIAL_TX_BREAK_EN
        @(negedge sys_clk);
        brk_s[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (!txo[0]) cnt++;
        end
        brk_s[0] = 1'b0;
        check("break_len", 0, cnt, 40);
        @(negedge sys_clk);
        check("break_exit", 0, int'(txo[0]), 1);
        send(0, 9'h04B);
        repeat (50) @(negedge sys_clk);
        brk_s[0] = 1'b1;
        repeat (130) @(negedge sys_clk);
        check("break_after_frame_tx", 0, int'(txo[0]), 0);
        check("break_after_frame_rdy", 0, int'(rdy[0]), 0);
        brk_s[0] = 1'b0;
        wait_ready(0, 10);
`endif

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
